fifo_rd_arbiter: RTL

- Read-side scheduler for the dual-clock FIFO, running entirely in the read clock domain.
- Shares the single FIFO read port among NUM_REQ consumers using round-robin arbitration with burst hold.
- Generates the FIFO read enable and returns each read word to the consumer that owns it, one cycle later.

---
 rtl/fifo_rd_arb_pkg.sv | 49 ++++
 rtl/fifo_rd_arbiter_rr_priority_sel.sv | 33 +++
 rtl/fifo_rd_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fifo_rd_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_arb_pkg
// Shared types and helpers for the FIFO read-side arbiter.
//   state_e    : arbiter FSM states (IDLE, GRANT)
//   rr_pick    : round-robin pick, search starts just above last_idx and wraps
//                modulo num_req
//   idx2onehot : index to one-hot vector
// Helpers work on a fixed maximum width (MAX_REQ consumers); callers extend
// their operands to that width and truncate the results.
// -----------------------------------------------------------------------------
package fifo_rd_arb_pkg;

   localparam int unsigned MAX_REQ   = 8;
   localparam int unsigned MAX_IDX_W = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   // Returns last_idx when nothing is requesting; callers gate with any_req.
   function automatic logic [MAX_IDX_W-1:0] rr_pick(
      input logic [MAX_REQ-1:0]   req,
      input logic [MAX_IDX_W-1:0] last_idx,
      input int unsigned          num_req
   );
      int unsigned idx;
      logic        found;
      rr_pick = last_idx;
      found   = 1'b0;
      for (int unsigned i = 1; i <= MAX_REQ; i++) begin
         // explicit wrap so non power-of-2 consumer counts rotate correctly
         idx = 32'(last_idx) + i;
         if (idx >= num_req) begin
            idx = idx - num_req;
         end
         if ((i <= num_req) && !found && req[idx[MAX_IDX_W-1:0]]) begin
            rr_pick = idx[MAX_IDX_W-1:0];
            found   = 1'b1;
         end
      end
   endfunction

   function automatic logic [MAX_REQ-1:0] idx2onehot(input logic [MAX_IDX_W-1:0] idx);
      idx2onehot      = '0;
      idx2onehot[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_priority_sel.sv
// -----------------------------------------------------------------------------
// rr_priority_sel
// Combinational rotate-and-priority-encode. Picks the first requester above
// last_idx, wrapping modulo NUM_REQ. Shared with the write-side arbiter.
// Ports:
//   req      in  [NUM_REQ-1:0] request vector
//   last_idx in  [IDX_W-1:0]   index served most recently (lowest priority)
//   sel_idx  out [IDX_W-1:0]   selected index (valid when any_req)
//   any_req  out               at least one request present
// -----------------------------------------------------------------------------
module rr_priority_sel
   import fifo_rd_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_idx,
   output logic [IDX_W-1:0]   sel_idx,
   output logic               any_req
);

   logic [MAX_REQ-1:0] req_ext;

   always_comb begin
      req_ext              = '0;
      req_ext[NUM_REQ-1:0] = req;
   end

   assign sel_idx = IDX_W'(rr_pick(req_ext, MAX_IDX_W'(last_idx), NUM_REQ));
   assign any_req = |req;

endmodule

// File: rtl/fifo_rd_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_rd_arbiter
// Read-side scheduler for the dual-clock FIFO (read clock domain only).
// Shares the FIFO read port among NUM_REQ consumers with round-robin
// arbitration and returns each popped word to its owner one cycle later.
// Build option: FIFO_RD_ARB_BURST_EN
//   defined   : a grant holds for up to BURST_LEN issued beats
//   undefined : a grant holds for exactly one issued beat (per-word round robin)
// Ports:
//   r_clk        in               read-domain clock
//   r_rstn       in               synchronous active-low reset
//   req          in  [NUM_REQ-1:0] consumer wants a word (and can take it next cycle)
//   fifo_empty   in               FIFO empty flag
//   fifo_r_data  in  [DATA_WIDTH-1:0] FIFO read data, one cycle after fifo_r_en
//   fifo_r_en    out              FIFO read enable
//   gnt          out [NUM_REQ-1:0] registered one-hot grant, zero when idle
//   rd_data      out [DATA_WIDTH-1:0] fifo_r_data passed through
//   rd_valid     out [NUM_REQ-1:0] one-hot owner of rd_data
// -----------------------------------------------------------------------------
module fifo_rd_arbiter
   import fifo_rd_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = 4
) (
   input  logic                  r_clk,
   input  logic                  r_rstn,
   input  logic [NUM_REQ-1:0]    req,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_r_data,
   output logic                  fifo_r_en,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [NUM_REQ-1:0]    rd_valid
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX_RST = IDX_W'(NUM_REQ - 1);

   if ((NUM_REQ < 2) || (NUM_REQ > 8) || (BURST_LEN < 2) ||
       ((BURST_LEN & (BURST_LEN - 1)) != 0)) begin : g_bad_params
      $error("fifo_rd_arbiter: NUM_REQ must be 2..8, BURST_LEN a power of 2 >= 2");
   end

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0]   own_idx_q, own_idx_d;
   logic [IDX_W-1:0]   last_idx_q, last_idx_d;
   logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d;

   logic [IDX_W-1:0]   sel_idx;
   logic               any_req;
   logic               owner_req;
   logic               issue;
   logic               last_beat;

`ifdef FIFO_RD_ARB_BURST_EN
   localparam int CNT_W = $clog2(BURST_LEN);
   logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
   assign last_beat = (beat_cnt_q == CNT_W'(BURST_LEN - 1));
`else
   assign last_beat = 1'b1;
`endif

   rr_priority_sel #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_sel (
      .req      (req),
      .last_idx (last_idx_q),
      .sel_idx  (sel_idx),
      .any_req  (any_req)
   );

   // Issue is gated by r_rstn so nothing is popped during a reset cycle.
   assign owner_req = |(req & gnt_q);
   assign issue     = (state_q == GRANT) && owner_req && !fifo_empty && r_rstn;

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      own_idx_d  = own_idx_q;
      last_idx_d = last_idx_q;
`ifdef FIFO_RD_ARB_BURST_EN
      beat_cnt_d = beat_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (any_req) begin
               gnt_d     = NUM_REQ'(idx2onehot(MAX_IDX_W'(sel_idx)));
               own_idx_d = sel_idx;
`ifdef FIFO_RD_ARB_BURST_EN
               beat_cnt_d = '0;
`endif
               state_d   = GRANT;
            end
         end
         GRANT: begin
            // Owner withdrew, or its final beat goes out now: release and
            // make the owner lowest priority for the next IDLE pick.
            if (!owner_req || (issue && last_beat)) begin
               gnt_d      = '0;
               last_idx_d = own_idx_q;
               state_d    = IDLE;
            end
`ifdef FIFO_RD_ARB_BURST_EN
            else if (issue) begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   assign rd_valid_d = gnt_q & {NUM_REQ{issue}};

   always_ff @(posedge r_clk) begin
      if (!r_rstn) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         own_idx_q  <= '0;
         last_idx_q <= LAST_IDX_RST;
         rd_valid_q <= '0;
`ifdef FIFO_RD_ARB_BURST_EN
         beat_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         own_idx_q  <= own_idx_d;
         last_idx_q <= last_idx_d;
         rd_valid_q <= rd_valid_d;
`ifdef FIFO_RD_ARB_BURST_EN
         beat_cnt_q <= beat_cnt_d;
`endif
      end
   end

   assign fifo_r_en = issue;
   assign gnt       = gnt_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = fifo_r_data;

endmodule
